// File: rtl/sha_pkg.sv
// Shared constants, loader state encoding and address helper for the SHA-256 front end.
package sha_pkg;

  localparam int WORD_W        = 32;
  localparam int BLOCK_W       = 512;
  localparam int WORDS_PER_BLK = 16;
  localparam int WORD_BYTES    = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    DRAIN   = 3'd2,
    PRESENT = 3'd3,
    FIN     = 3'd4
  } ld_state_e;

  // Byte address of a word, counted from the job base; wraps modulo 2^32.
  function automatic logic [WORD_W-1:0] word_addr(input logic [WORD_W-1:0] base,
                                                  input logic [WORD_W-1:0] word_num);
    return base + (word_num * WORD_W'(WORD_BYTES));
  endfunction

endpackage

// File: rtl/rd_lat_pipe.sv
// Delay line of read-request valid bits; its tail marks the cycle in which
// the matching read data is present on the memory data bus.
module rd_lat_pipe #(
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic i_req,
  output logic o_cap_stb
);

  logic [RD_LAT-1:0] r_vld;

  // Shift the request tag along one stage per cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_vld <= '0;
    end else begin
      r_vld[0] <= i_req;
      for (int k = 1; k < RD_LAT; k++) begin
        r_vld[k] <= r_vld[k-1];
      end
    end
  end

  assign o_cap_stb = r_vld[RD_LAT-1];

endmodule

// File: rtl/rd_data2blk.sv
// Message loader for the SHA-256 core: reads num_blocks 512-bit blocks one
// word per cycle, packs them big-endian and hands each over on valid/ready.
module rd_data2blk
  import sha_pkg::*;
#(
  parameter int RD_LAT    = 1,
  parameter int MAX_BLK_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WORD_W-1:0]    base_addr,
  input  logic [MAX_BLK_W-1:0] num_blocks,
  output logic                 en_r_datamem,
  output logic [WORD_W-1:0]    addr_rd,
  input  logic [WORD_W-1:0]    data_rd,
  output logic [BLOCK_W-1:0]   block_out,
  output logic                 block_valid,
  input  logic                 block_ready,
  output logic                 last_block,
  output logic                 busy,
  output logic                 done
);

  ld_state_e            r_state;
  logic [WORD_W-1:0]    r_base;
  logic [MAX_BLK_W-1:0] r_nblk;
  logic [MAX_BLK_W-1:0] r_blk_idx;
  logic [3:0]           r_word_idx;
  logic [3:0]           r_cap_cnt;
  logic                 w_cap_stb;
  logic                 w_blk_last;

  assign w_blk_last = (r_blk_idx == (r_nblk - MAX_BLK_W'(1)));

  rd_lat_pipe #(.RD_LAT(RD_LAT)) u_lat_pipe (
    .clk       (clk),
    .reset     (reset),
    .i_req     (en_r_datamem),
    .o_cap_stb (w_cap_stb)
  );

  // Tagged read data lands in slot r_cap_cnt; word 0 occupies the top bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cap_cnt <= 4'd0;
      block_out <= '0;
    end else if (w_cap_stb) begin
      block_out[(WORDS_PER_BLK - 1 - int'(r_cap_cnt)) * WORD_W +: WORD_W] <= data_rd;
      r_cap_cnt <= r_cap_cnt + 4'd1;
    end
  end

  // Loader sequencing: fetch 16 words, wait for the tail, present, repeat.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_base       <= '0;
      r_nblk       <= '0;
      r_blk_idx    <= '0;
      r_word_idx   <= 4'd0;
      en_r_datamem <= 1'b0;
      addr_rd      <= '0;
      block_valid  <= 1'b0;
      last_block   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            busy <= 1'b1;
            if (num_blocks == '0) begin
              done    <= 1'b1;
              r_state <= FIN;
            end else begin
              r_base       <= base_addr;
              r_nblk       <= num_blocks;
              r_blk_idx    <= '0;
              r_word_idx   <= 4'd0;
              en_r_datamem <= 1'b1;
              addr_rd      <= base_addr;
              r_state      <= FETCH;
            end
          end
        end
        FETCH: begin
          if (r_word_idx == 4'd15) begin
            en_r_datamem <= 1'b0;
            r_word_idx   <= 4'd0;
            r_state      <= DRAIN;
          end else begin
            r_word_idx <= r_word_idx + 4'd1;
            addr_rd    <= word_addr(r_base, WORD_W'({r_blk_idx, r_word_idx + 4'd1}));
          end
        end
        DRAIN: begin
          if (w_cap_stb && (r_cap_cnt == 4'd15)) begin
            block_valid <= 1'b1;
            last_block  <= w_blk_last;
            r_state     <= PRESENT;
          end
        end
        PRESENT: begin
          if (block_ready) begin
            block_valid <= 1'b0;
            last_block  <= 1'b0;
            if (last_block) begin
              done    <= 1'b1;
              r_state <= FIN;
            end else begin
              // Next block starts right after the handshake; no prefetch overlap.
              r_blk_idx    <= r_blk_idx + MAX_BLK_W'(1);
              r_word_idx   <= 4'd0;
              en_r_datamem <= 1'b1;
              addr_rd      <= word_addr(r_base, WORD_W'({r_blk_idx + MAX_BLK_W'(1), 4'd0}));
              r_state      <= FETCH;
            end
          end
        end
        FIN: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          en_r_datamem <= 1'b0;
          block_valid  <= 1'b0;
          last_block   <= 1'b0;
          busy         <= 1'b0;
          done         <= 1'b0;
          r_state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rd_data2blk.sv
// Randomised bench for rd_data2blk: two instances (RD_LAT=1 and RD_LAT=3) share the
// job stimulus and are checked every cycle against a job-level model of reads and blocks.
module tb_rd_data2blk;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [31:0]  base_addr;
  logic [7:0]   num_blocks;
  logic         en     [2];
  logic [31:0]  addr   [2];
  logic [31:0]  data_rd[2];
  logic [511:0] blk    [2];
  logic         bv     [2];
  logic         rdy    [2];
  logic         last   [2];
  logic         busy   [2];
  logic         done   [2];

  always #5 clk = ~clk;

  rd_data2blk #(.RD_LAT(1), .MAX_BLK_W(8)) dut_l1 (
    .clk(clk), .reset(rst_n), .start(start), .base_addr(base_addr), .num_blocks(num_blocks),
    .en_r_datamem(en[0]), .addr_rd(addr[0]), .data_rd(data_rd[0]), .block_out(blk[0]),
    .block_valid(bv[0]), .block_ready(rdy[0]), .last_block(last[0]), .busy(busy[0]), .done(done[0])
  );

  rd_data2blk #(.RD_LAT(3), .MAX_BLK_W(8)) dut_l3 (
    .clk(clk), .reset(rst_n), .start(start), .base_addr(base_addr), .num_blocks(num_blocks),
    .en_r_datamem(en[1]), .addr_rd(addr[1]), .data_rd(data_rd[1]), .block_out(blk[1]),
    .block_valid(bv[1]), .block_ready(rdy[1]), .last_block(last[1]), .busy(busy[1]), .done(done[1])
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] mem_key;
  int          ready_mode;
  logic [31:0] mp [2][0:3];
  int          stall_cnt [2];

  function automatic logic [31:0] mem_word(input logic [31:0] a, input logic [31:0] key);
    return (32'h1000_0000 + ((a - 32'h0000_0100) >> 2)) ^ key;
  endfunction

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  // Memory with fixed read latency and the SHA-side ready policy, both driven mid-cycle.
  always @(negedge clk) begin
    #1;
    for (int d = 0; d < 2; d++) begin
      for (int k = 3; k > 0; k--) mp[d][k] = mp[d][k-1];
      mp[d][0]   = en[d] ? mem_word(addr[d], mem_key) : $urandom;
      data_rd[d] = mp[d][lat_of(d)];
      if (!bv[d]) begin
        stall_cnt[d] = 0;
        rdy[d] = (ready_mode == 1) ? 1'b0 : ((ready_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1);
      end else begin
        case (ready_mode)
          0:       rdy[d] = 1'b1;
          1:       rdy[d] = (stall_cnt[d] >= 5);
          default: rdy[d] = 1'($urandom_range(0, 1));
        endcase
        stall_cnt[d]++;
      end
    end
  end

  // Model: expected read addresses, blocks and done pulses per instance.
  logic [31:0]  exp_addr [2][$];
  logic [511:0] exp_blk  [2][$];
  logic         exp_last [2][$];
  int           pend_done[2];
  int           en_tot[2], bv_tot[2], done_tot[2], busy_tot[2], run_len[2];
  int           bv_rise_cyc[2], done_cyc[2];
  logic         prev_bv[2];
  logic [511:0] acc_blk[2];
  logic [31:0]  addr_hist[2][0:4095];
  int           s_en[2], s_bv[2], s_done[2], s_busy[2];
  int           n_cmp, n_fail, c0;

  task automatic chk(input string nm, input int d, input logic [511:0] got, input logic [511:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0h want %0h", nm, d, got, exp);
    end
  endtask

  task automatic fail_evt(input string nm, input int d);
    n_cmp++;
    n_fail++;
    $display("FAIL %s dut%0d: event with no matching expectation", nm, d);
  endtask

  task automatic add_job(input logic [31:0] base, input int n);
    for (int d = 0; d < 2; d++) begin
      pend_done[d]++;
      for (int b = 0; b < n; b++) begin
        logic [511:0] bb;
        bb = '0;
        for (int w = 0; w < 16; w++) begin
          logic [31:0] a;
          a = base + 32'((b * 16 + w) * 4);
          exp_addr[d].push_back(a);
          bb = {bb[479:0], mem_word(a, mem_key)};
        end
        exp_blk[d].push_back(bb);
        exp_last[d].push_back(b == n - 1);
      end
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      exp_addr[d].delete();
      exp_blk[d].delete();
      exp_last[d].delete();
      pend_done[d] = 0;
      run_len[d]   = 0;
      prev_bv[d]   = 1'b0;
    end
  endtask

  task automatic check_cycle();
    if (rst_n !== 1'b1) return;
    for (int d = 0; d < 2; d++) begin
      if (en[d]) begin
        addr_hist[d][en_tot[d] % 4096] = addr[d];
        en_tot[d]++;
        run_len[d]++;
        if (exp_addr[d].size() == 0) fail_evt("unexpected_read", d);
        else chk("rd_addr", d, addr[d], exp_addr[d].pop_front());
      end else if (run_len[d] != 0) begin
        chk("req_burst_len", d, run_len[d], 16);
        run_len[d] = 0;
      end
      if (bv[d]) begin
        bv_tot[d]++;
        if (!prev_bv[d]) bv_rise_cyc[d] = cyc;
        if (exp_blk[d].size() == 0) fail_evt("unexpected_block", d);
        else begin
          chk("block_out", d, blk[d], exp_blk[d][0]);
          chk("last_block", d, last[d], exp_last[d][0]);
          if (rdy[d]) begin
            acc_blk[d] = blk[d];
            void'(exp_blk[d].pop_front());
            void'(exp_last[d].pop_front());
          end
        end
      end else begin
        chk("last_without_valid", d, last[d], 1'b0);
      end
      prev_bv[d] = bv[d];
      if (done[d]) begin
        done_tot[d]++;
        done_cyc[d] = cyc;
        if (pend_done[d] == 0) fail_evt("spurious_done", d);
        else begin
          pend_done[d]--;
          chk("reads_left_at_done", d, exp_addr[d].size(), 0);
          chk("blocks_left_at_done", d, exp_blk[d].size(), 0);
        end
      end
      if (busy[d]) busy_tot[d]++;
      if (en[d] || bv[d] || done[d]) chk("busy_when_active", d, busy[d], 1'b1);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #2;
    check_cycle();
  endtask

  task automatic take_snap();
    for (int d = 0; d < 2; d++) begin
      s_en[d] = en_tot[d]; s_bv[d] = bv_tot[d]; s_done[d] = done_tot[d]; s_busy[d] = busy_tot[d];
    end
  endtask

  task automatic start_job(input logic [31:0] base, input int n);
    base_addr  = base;
    num_blocks = 8'(n);
    start      = 1'b1;
    add_job(base, n);
    c0 = cyc;
    tick();
    start      = 1'b0;
    base_addr  = $urandom;
    num_blocks = 8'($urandom);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((pend_done[0] > 0 || pend_done[1] > 0) && n < budget) begin
      tick();
      n++;
    end
    if (pend_done[0] > 0 || pend_done[1] > 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL done_timeout: no done within %0d cycles", budget);
      model_reset();
    end
    tick();
    for (int d = 0; d < 2; d++) chk("idle_busy", d, busy[d], 1'b0);
  endtask

  task automatic chk_zero_outputs(input string nm);
    for (int d = 0; d < 2; d++) begin
      chk({nm, "_block_out"}, d, blk[d], '0);
      chk({nm, "_ctrl"}, d, {en[d], addr[d], bv[d], last[d], busy[d], done[d]}, '0);
    end
  endtask

  initial begin
    logic [31:0] b;
    int          k;
    n_cmp = 0; n_fail = 0;
    start = 1'b0; base_addr = '0; num_blocks = '0; ready_mode = 0; mem_key = '0;
    for (int d = 0; d < 2; d++) begin
      en_tot[d] = 0; bv_tot[d] = 0; done_tot[d] = 0; busy_tot[d] = 0;
      bv_rise_cyc[d] = 0; done_cyc[d] = 0; acc_blk[d] = '0;
    end
    model_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    chk_zero_outputs("reset");
    rst_n = 1'b1;
    tick(); tick();

    // Single block, RD_LAT 1 and 3, known memory contents.
    ready_mode = 0; mem_key = 32'h0;
    take_snap();
    start_job(32'h0000_0100, 1);
    k = c0;
    wait_idle(200);
    chk("t1_valid_cycle", 0, bv_rise_cyc[0] - k, 18);
    chk("t1_valid_cycle", 1, bv_rise_cyc[1] - k, 20);
    chk("t1_done_cycle", 0, done_cyc[0] - k, 19);
    chk("t1_done_cycle", 1, done_cyc[1] - k, 21);
    for (int d = 0; d < 2; d++) begin
      chk("t1_word0", d, acc_blk[d][511:480], 32'h1000_0000);
      chk("t1_word15", d, acc_blk[d][31:0], 32'h1000_000F);
      chk("t1_valid_len", d, bv_tot[d] - s_bv[d], 1);
      chk("t1_first_addr", d, addr_hist[d][s_en[d] % 4096], 32'h0000_0100);
      chk("t1_last_addr", d, addr_hist[d][(s_en[d] + 15) % 4096], 32'h0000_013C);
    end

    // Three blocks with five stall cycles per presentation.
    ready_mode = 1; mem_key = $urandom; b = $urandom & 32'hFFFF_FFFC;
    take_snap();
    start_job(b, 3);
    wait_idle(600);
    for (int d = 0; d < 2; d++) begin
      chk("t2_valid_cycles", d, bv_tot[d] - s_bv[d], 18);
      chk("t2_done_count", d, done_tot[d] - s_done[d], 1);
      chk("t2_blk2_addr", d, addr_hist[d][(s_en[d] + 16) % 4096], b + 32'h40);
    end

    // Empty job.
    ready_mode = 0;
    take_snap();
    start_job($urandom & 32'hFFFF_FFFC, 0);
    k = c0;
    wait_idle(20);
    for (int d = 0; d < 2; d++) begin
      chk("t3_done_cycle", d, done_cyc[d] - k, 1);
      chk("t3_busy_cycles", d, busy_tot[d] - s_busy[d], 1);
      chk("t3_reads", d, en_tot[d] - s_en[d], 0);
    end

    // Start pulse during FETCH must be ignored.
    ready_mode = 2; mem_key = $urandom; b = $urandom & 32'hFFFF_FFFC;
    take_snap();
    start_job(b, 2);
    repeat (5) tick();
    base_addr = b + 32'h1000; num_blocks = 8'd5; start = 1'b1;
    tick();
    start = 1'b0;
    wait_idle(1000);
    for (int d = 0; d < 2; d++) begin
      chk("t4_reads", d, en_tot[d] - s_en[d], 32);
      chk("t4_done_count", d, done_tot[d] - s_done[d], 1);
    end

    // Reset after seven reads aborts the job, then a clean job runs.
    ready_mode = 0; mem_key = $urandom;
    take_snap();
    start_job($urandom & 32'hFFFF_FFFC, 2);
    k = 0;
    while ((en_tot[0] - s_en[0]) < 7 && k < 40) begin
      tick();
      k++;
    end
    chk("t5_reads_before_reset", 0, en_tot[0] - s_en[0], 7);
    rst_n = 1'b0;
    #1;
    chk_zero_outputs("t5_reset");
    model_reset();
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (6) tick();
    for (int d = 0; d < 2; d++) chk("t5_no_done", d, done_tot[d] - s_done[d], 0);
    take_snap();
    start_job($urandom & 32'hFFFF_FFFC, 2);
    wait_idle(600);
    for (int d = 0; d < 2; d++) chk("t5_clean_done", d, done_tot[d] - s_done[d], 1);

    // Address wrap-around inside a block.
    ready_mode = 0; mem_key = $urandom;
    take_snap();
    start_job(32'hFFFF_FFE0, 1);
    k = c0;
    wait_idle(200);
    for (int d = 0; d < 2; d++) begin
      chk("t6_addr7", d, addr_hist[d][(s_en[d] + 7) % 4096], 32'hFFFF_FFFC);
      chk("t6_addr8", d, addr_hist[d][(s_en[d] + 8) % 4096], 32'h0000_0000);
    end
    chk("t6_valid_cycle", 0, bv_rise_cyc[0] - k, 18);
    chk("t6_valid_cycle", 1, bv_rise_cyc[1] - k, 20);

    // Random jobs under random ready behaviour.
    for (int j = 0; j < 8; j++) begin
      ready_mode = $urandom_range(0, 2);
      mem_key    = $urandom;
      take_snap();
      k = $urandom_range(1, 4);
      start_job($urandom & 32'hFFFF_FFFC, k);
      wait_idle(2000);
      for (int d = 0; d < 2; d++) chk("rand_reads", d, en_tot[d] - s_en[d], 16 * k);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
